// File: rtl/ddr_port_arbiter.sv
// Two-port DDR command arbiter: video burst reads (port 0) and CPU single-word
// accesses (port 1) share one controller command channel. Read bursts are
// tagged in a small FIFO so returning data can be steered to its owner.
module ddr_port_arbiter #(
    parameter int unsigned g_addr_width   = 24,
    parameter int unsigned g_data_width   = 32,
    parameter int unsigned g_len_width    = 6,
    parameter int unsigned g_starve_limit = 4,
    parameter int unsigned g_tag_depth    = 4
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_i,
    // video port
    input  logic                      p0_req_i,
    input  logic [g_addr_width-1:0]   p0_addr_i,
    input  logic [g_len_width-1:0]    p0_len_i,
    output logic                      p0_ack_o,
    output logic [g_data_width-1:0]   p0_rdata_o,
    output logic                      p0_rvalid_o,
    // CPU port
    input  logic                      p1_req_i,
    input  logic                      p1_we_i,
    input  logic [g_addr_width-1:0]   p1_addr_i,
    input  logic [g_data_width-1:0]   p1_wdata_i,
    input  logic [g_data_width/8-1:0] p1_wmask_i,
    output logic                      p1_ack_o,
    output logic [g_data_width-1:0]   p1_rdata_o,
    output logic                      p1_rvalid_o,
    // controller side
    output logic                      cmd_valid_o,
    input  logic                      cmd_ready_i,
    output logic                      cmd_we_o,
    output logic [g_addr_width-1:0]   cmd_addr_o,
    output logic [g_len_width-1:0]    cmd_len_o,
    output logic [g_data_width-1:0]   cmd_wdata_o,
    output logic [g_data_width/8-1:0] cmd_wmask_o,
    input  logic [g_data_width-1:0]   rdata_i,
    input  logic                      rvalid_i,
    output logic                      err_o
);

    localparam int unsigned c_mask_w   = g_data_width / 8;
    localparam int unsigned c_ptr_w    = (g_tag_depth > 1) ? $clog2(g_tag_depth) : 1;
    localparam int unsigned c_cnt_w    = $clog2(g_tag_depth + 1);
    localparam int unsigned c_starve_w = (g_starve_limit > 0) ? $clog2(g_starve_limit + 1) : 1;

    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

    state_t                  state_q, state_d;
    logic                    cmd_valid_q, cmd_we_q, owner_q;
    logic [g_addr_width-1:0] cmd_addr_q;
    logic [g_len_width-1:0]  cmd_len_q;
    logic [g_data_width-1:0] cmd_wdata_q;
    logic [c_mask_w-1:0]     cmd_wmask_q;
    logic [c_starve_w-1:0]   starve_q;
    logic [c_ptr_w-1:0]      wr_ptr_q, rd_ptr_q;
    logic [c_cnt_w-1:0]      count_q;
    logic [g_len_width-1:0]  wcnt_q;
    logic                    tag_port_q [g_tag_depth];
    logic [g_len_width-1:0]  tag_len_q  [g_tag_depth];
    logic                    p0_rvalid_q, p1_rvalid_q, err_q;
    logic [g_data_width-1:0] p0_rdata_q, p1_rdata_q;

    logic fifo_full, fifo_empty, p0_elig, p1_elig, grant_p0, grant_p1;
    logic accept, push, pop, rd_hit, head_port, last_word;
    logic [g_len_width-1:0] head_len;

    // State register
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: leave IDLE on any grant, leave ISSUE on controller acceptance
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_p0 || grant_p1) state_d = ST_ISSUE;
            ST_ISSUE: if (cmd_ready_i)          state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/decision decode: eligibility, grant, ack, tag FIFO control
    always_comb begin
        fifo_full  = (count_q == c_cnt_w'(g_tag_depth));
        fifo_empty = (count_q == '0);
        // a full tag FIFO blocks reads only; a CPU write stays eligible
        p0_elig    = p0_req_i && !fifo_full;
        p1_elig    = p1_req_i && (p1_we_i || !fifo_full);
        grant_p0   = 1'b0;
        grant_p1   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (p0_elig && !(p1_elig && starve_q == c_starve_w'(g_starve_limit))) grant_p0 = 1'b1;
            else if (p1_elig)                                                     grant_p1 = 1'b1;
        end
        // an acceptance coinciding with reset is aborted, so no ack
        accept    = (state_q == ST_ISSUE) && cmd_ready_i && !rst_i;
        p0_ack_o  = accept && !owner_q;
        p1_ack_o  = accept && owner_q;
        push      = accept && !cmd_we_q;
        head_port = tag_port_q[rd_ptr_q];
        head_len  = tag_len_q[rd_ptr_q];
        rd_hit    = rvalid_i && !fifo_empty;
        last_word = (({1'b0, wcnt_q} + (g_len_width + 1)'(1)) == {1'b0, head_len});
        pop       = rd_hit && last_word;
    end

    // Tag storage; contents are meaningless while unoccupied, so no reset
    always_ff @(posedge clk_sys_i) begin
        if (push) begin
            tag_port_q[wr_ptr_q] <= owner_q;
            tag_len_q[wr_ptr_q]  <= cmd_len_q;
        end
    end

    // Command register, starvation counter, tag pointers, read steering, error flag
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            owner_q     <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            cmd_wdata_q <= '0;
            cmd_wmask_q <= '0;
            starve_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wcnt_q      <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (grant_p0) begin
                cmd_valid_q <= 1'b1;
                cmd_we_q    <= 1'b0;
                owner_q     <= 1'b0;
                cmd_addr_q  <= p0_addr_i;
                cmd_len_q   <= (p0_len_i == '0) ? g_len_width'(1) : p0_len_i;
                cmd_wdata_q <= '0;
                cmd_wmask_q <= '0;
            end else if (grant_p1) begin
                cmd_valid_q <= 1'b1;
                cmd_we_q    <= p1_we_i;
                owner_q     <= 1'b1;
                cmd_addr_q  <= p1_addr_i;
                cmd_len_q   <= g_len_width'(1);
                cmd_wdata_q <= p1_we_i ? p1_wdata_i : '0;
                cmd_wmask_q <= p1_we_i ? p1_wmask_i : '0;
            end else if (accept) begin
                cmd_valid_q <= 1'b0;
            end

            if (grant_p1)
                starve_q <= '0;
            else if (grant_p0 && p1_elig && starve_q != c_starve_w'(g_starve_limit))
                starve_q <= starve_q + c_starve_w'(1);

            // depth is a power of two, so pointers wrap naturally
            if (push) wr_ptr_q <= wr_ptr_q + c_ptr_w'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + c_ptr_w'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + c_cnt_w'(1);
                2'b01:   count_q <= count_q - c_cnt_w'(1);
                default: count_q <= count_q;
            endcase

            if (rd_hit) wcnt_q <= last_word ? '0 : wcnt_q + g_len_width'(1);

            p0_rvalid_q <= rd_hit && !head_port;
            p1_rvalid_q <= rd_hit && head_port;
            if (rd_hit && !head_port) p0_rdata_q <= rdata_i;
            if (rd_hit && head_port)  p1_rdata_q <= rdata_i;

            if (rvalid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_we_o    = cmd_we_q;
    assign cmd_addr_o  = cmd_addr_q;
    assign cmd_len_o   = cmd_len_q;
    assign cmd_wdata_o = cmd_wdata_q;
    assign cmd_wmask_o = cmd_wmask_q;
    assign p0_rvalid_o = p0_rvalid_q;
    assign p1_rvalid_o = p1_rvalid_q;
    assign p0_rdata_o  = p0_rdata_q;
    assign p1_rdata_o  = p1_rdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Randomized scoreboard bench for ddr_port_arbiter: a transaction-level model
// decides grants, acks and read routing; a monitor compares DUT outputs.
`timescale 1ns/1ps
module tb_ddr_port_arbiter;

    localparam int AW = 24, DW = 32, LW = 6, SL = 4, TD = 4, MW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i;
    logic          p0_req_i, p0_ack_o, p0_rvalid_o;
    logic [AW-1:0] p0_addr_i;
    logic [LW-1:0] p0_len_i;
    logic [DW-1:0] p0_rdata_o;
    logic          p1_req_i, p1_we_i, p1_ack_o, p1_rvalid_o;
    logic [AW-1:0] p1_addr_i;
    logic [DW-1:0] p1_wdata_i, p1_rdata_o;
    logic [MW-1:0] p1_wmask_i;
    logic          cmd_valid_o, cmd_ready_i, cmd_we_o, rvalid_i, err_o;
    logic [AW-1:0] cmd_addr_o;
    logic [LW-1:0] cmd_len_o;
    logic [DW-1:0] cmd_wdata_o, rdata_i;
    logic [MW-1:0] cmd_wmask_o;

    ddr_port_arbiter #(
        .g_addr_width(AW), .g_data_width(DW), .g_len_width(LW),
        .g_starve_limit(SL), .g_tag_depth(TD)
    ) dut (
        .clk_sys_i(clk), .rst_i(rst_i),
        .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_len_i(p0_len_i),
        .p0_ack_o(p0_ack_o), .p0_rdata_o(p0_rdata_o), .p0_rvalid_o(p0_rvalid_o),
        .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i),
        .p1_wdata_i(p1_wdata_i), .p1_wmask_i(p1_wmask_i), .p1_ack_o(p1_ack_o),
        .p1_rdata_o(p1_rdata_o), .p1_rvalid_o(p1_rvalid_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_we_o(cmd_we_o),
        .cmd_addr_o(cmd_addr_o), .cmd_len_o(cmd_len_o), .cmd_wdata_o(cmd_wdata_o),
        .cmd_wmask_o(cmd_wmask_o), .rdata_i(rdata_i), .rvalid_i(rvalid_i), .err_o(err_o)
    );

    typedef struct {
        bit          port;
        bit          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        int          due;
    } cmd_t;
    typedef struct { bit port; logic [DW-1:0] data; int due; } rd_t;
    typedef struct { bit port; int due; } ack_t;
    typedef struct { bit port; int rem; } burst_t;

    cmd_t   exp_cmd[$];
    rd_t    exp_rd[$];
    ack_t   exp_ack[$];
    burst_t m_out[$];

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: event presence differs from expected", name, cyc);
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit   m_busy = 0, m_err = 0, exp_err_vis = 0;
    int   m_starve = 0;
    cmd_t m_cur;

    always @(negedge clk) begin
        int     occ;
        bit     push_b, v_ok, c_ok;
        cmd_t   c;
        burst_t h;
        exp_err_vis = m_err;
        if (rst_i) begin
            m_busy = 0; m_starve = 0; m_err = 0;
            m_out.delete();
        end else begin
            occ    = m_out.size();
            push_b = 0;
            if (m_busy) begin
                if (cmd_ready_i) begin
                    exp_ack.push_back('{port: m_cur.port, due: cyc});
                    push_b = !m_cur.we;
                    m_busy = 0;
                end
            end else begin
                v_ok = p0_req_i && occ < TD;
                c_ok = p1_req_i && (p1_we_i || occ < TD);
                c.due = cyc + 1;
                if (v_ok && !(c_ok && m_starve >= SL)) begin
                    c.port = 0; c.we = 0; c.addr = p0_addr_i;
                    c.len = (p0_len_i == 0) ? LW'(1) : p0_len_i;
                    c.wdata = '0; c.wmask = '0;
                    if (c_ok) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
                    exp_cmd.push_back(c); m_cur = c; m_busy = 1;
                end else if (c_ok) begin
                    c.port = 1; c.we = p1_we_i; c.addr = p1_addr_i; c.len = LW'(1);
                    c.wdata = p1_we_i ? p1_wdata_i : '0;
                    c.wmask = p1_we_i ? p1_wmask_i : '0;
                    m_starve = 0;
                    exp_cmd.push_back(c); m_cur = c; m_busy = 1;
                end
            end
            if (rvalid_i) begin
                if (m_out.size() == 0) m_err = 1;
                else begin
                    h = m_out[0];
                    exp_rd.push_back('{port: h.port, data: rdata_i, due: cyc + 1});
                    h.rem--;
                    if (h.rem == 0) void'(m_out.pop_front());
                    else m_out[0] = h;
                end
            end
            if (push_b) m_out.push_back('{port: m_cur.port, rem: int'(m_cur.len)});
        end
    end

    // ---------------- monitor ----------------
    bit have_cmd = 0;
    logic [AW+LW:0]   cap_a;
    logic [DW+MW-1:0] cap_b;

    always @(negedge clk) begin
        cmd_t e;
        rd_t  r;
        ack_t a;
        #1;
        if (cmd_valid_o) begin
            if (!have_cmd) begin
                if (exp_cmd.size() == 0) fail("cmd_unexpected");
                else begin
                    e = exp_cmd.pop_front();
                    chk("cmd_latency", cyc, e.due);
                    chk("cmd_we", cmd_we_o, e.we);
                    chk("cmd_addr", cmd_addr_o, e.addr);
                    chk("cmd_len", cmd_len_o, e.len);
                    chk("cmd_wdata", cmd_wdata_o, e.wdata);
                    chk("cmd_wmask", cmd_wmask_o, e.wmask);
                end
                cap_a = {cmd_we_o, cmd_addr_o, cmd_len_o};
                cap_b = {cmd_wdata_o, cmd_wmask_o};
                have_cmd = 1;
            end else begin
                chk("cmd_hold_ctl", {cmd_we_o, cmd_addr_o, cmd_len_o}, cap_a);
                chk("cmd_hold_data", {cmd_wdata_o, cmd_wmask_o}, cap_b);
            end
            if (cmd_ready_i || rst_i) have_cmd = 0;
        end else begin
            have_cmd = 0;
            if (exp_cmd.size() != 0 && exp_cmd[0].due <= cyc) begin
                fail("cmd_missing");
                void'(exp_cmd.pop_front());
            end
        end

        if (p0_rvalid_o || p1_rvalid_o) begin
            if (exp_rd.size() == 0) fail("rd_unexpected");
            else begin
                r = exp_rd.pop_front();
                chk("rd_latency", cyc, r.due);
                chk("rd_port_sel", {p1_rvalid_o, p0_rvalid_o}, r.port ? 2'b10 : 2'b01);
                chk("rd_data", r.port ? p1_rdata_o : p0_rdata_o, r.data);
            end
        end else if (exp_rd.size() != 0 && exp_rd[0].due <= cyc) begin
            fail("rd_missing");
            void'(exp_rd.pop_front());
        end

        if (p0_ack_o || p1_ack_o) begin
            if (exp_ack.size() == 0) fail("ack_unexpected");
            else begin
                a = exp_ack.pop_front();
                chk("ack_latency", cyc, a.due);
                chk("ack_port", {p1_ack_o, p0_ack_o}, a.port ? 2'b10 : 2'b01);
            end
        end else if (exp_ack.size() != 0 && exp_ack[0].due <= cyc) begin
            fail("ack_missing");
            void'(exp_ack.pop_front());
        end

        chk("err_flag", err_o, exp_err_vis);
    end

    // ---------------- requesters ----------------
    bit en0 = 0, en1 = 0, ack0_seen = 0, ack1_seen = 0;
    int req0_pct = 100, req1_pct = 100, we_pct = 50;

    always @(negedge clk) begin
        if (p0_ack_o) ack0_seen = 1;
        if (p1_ack_o) ack1_seen = 1;
    end

    initial begin
        int wc;
        p0_req_i = 0; p0_addr_i = '0; p0_len_i = '0; wc = 0;
        forever begin
            @(posedge clk); #1;
            if (p0_req_i) begin
                if (ack0_seen) begin ack0_seen = 0; p0_req_i = 0; wc = 0; end
                else if (++wc > 3000) begin fail("p0_ack_timeout"); p0_req_i = 0; wc = 0; end
            end
            if (!p0_req_i && en0 && $urandom_range(99) < req0_pct) begin
                p0_req_i  = 1;
                p0_addr_i = AW'($urandom);
                p0_len_i  = LW'($urandom_range(0, 10));
            end
        end
    end

    initial begin
        int wc;
        p1_req_i = 0; p1_we_i = 0; p1_addr_i = '0; p1_wdata_i = '0; p1_wmask_i = '0; wc = 0;
        forever begin
            @(posedge clk); #1;
            if (p1_req_i) begin
                if (ack1_seen) begin ack1_seen = 0; p1_req_i = 0; wc = 0; end
                else if (++wc > 3000) begin fail("p1_ack_timeout"); p1_req_i = 0; wc = 0; end
            end
            if (!p1_req_i && en1 && $urandom_range(99) < req1_pct) begin
                p1_req_i   = 1;
                p1_we_i    = ($urandom_range(99) < we_pct);
                p1_addr_i  = AW'($urandom);
                p1_wdata_i = $urandom;
                p1_wmask_i = MW'($urandom);
            end
        end
    end

    // ---------------- controller ----------------
    int rdy_pct = 100, rv_pct = 100, ctl_words = 0;
    bit ctl_keep = 0, stray = 0;

    always @(negedge clk) begin
        if (rst_i) begin
            if (!ctl_keep) ctl_words = 0;
        end else if (cmd_valid_o && cmd_ready_i && !cmd_we_o) begin
            ctl_words += int'(cmd_len_o);
        end
    end

    initial begin
        cmd_ready_i = 0; rvalid_i = 0; rdata_i = '0;
        forever begin
            @(posedge clk); #2;
            cmd_ready_i = ($urandom_range(99) < rdy_pct);
            if (stray || (ctl_words > 0 && $urandom_range(99) < rv_pct)) begin
                rvalid_i = 1;
                rdata_i  = $urandom;
                if (!stray && ctl_words > 0) ctl_words--;
            end else begin
                rvalid_i = 0;
            end
        end
    end

    // ---------------- main sequence ----------------
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_valid"}, cmd_valid_o, 0);
        chk({tag, "_cmd_fields"}, {cmd_we_o, cmd_addr_o, cmd_len_o, cmd_wmask_o}, 0);
        chk({tag, "_cmd_wdata"}, cmd_wdata_o, 0);
        chk({tag, "_acks"}, {p1_ack_o, p0_ack_o}, 0);
        chk({tag, "_rvalids"}, {p1_rvalid_o, p0_rvalid_o}, 0);
        chk({tag, "_rdata0"}, p0_rdata_o, 0);
        chk({tag, "_rdata1"}, p1_rdata_o, 0);
        chk({tag, "_err"}, err_o, 0);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk); #1 rst_i = 1;
        @(posedge clk); #1 rst_i = 0;
        #2 check_reset_outputs(tag);
    endtask

    task automatic drain();
        en0 = 0; en1 = 0; rdy_pct = 100; rv_pct = 100;
        for (int i = 0; i < 3000 && (p0_req_i || p1_req_i); i++) @(posedge clk);
        if (p0_req_i || p1_req_i) fail("drain_req_timeout");
        for (int i = 0; i < 3000 && ctl_words > 0; i++) @(posedge clk);
        if (ctl_words > 0) fail("drain_data_timeout");
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int stale;
        rst_i = 1;
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        #2 check_reset_outputs("init");

        // both ports saturating: starvation limit decides the grant pattern
        en0 = 1; en1 = 1; req0_pct = 100; req1_pct = 100; we_pct = 50;
        repeat (300) @(posedge clk);

        // random traffic, slow controller
        #1 req0_pct = 30; req1_pct = 40; rdy_pct = 40; rv_pct = 30;
        repeat (1500) @(posedge clk);

        // no read data: tag FIFO fills, writes must still flow
        #1 req0_pct = 100; req1_pct = 100; rdy_pct = 100; rv_pct = 0; we_pct = 40;
        repeat (150) @(posedge clk);
        #1 rv_pct = 100;
        repeat (300) @(posedge clk);

        // controller stall: command must be held steady
        #1 rdy_pct = 0;
        repeat (12) @(posedge clk);
        #1 rdy_pct = 100;
        repeat (50) @(posedge clk);

        // reset while a command is pending and read tags are outstanding
        drain();
        en0 = 1; en1 = 1; req0_pct = 100; req1_pct = 100; rv_pct = 0; rdy_pct = 100;
        for (int i = 0; i < 300 && m_out.size() < 2; i++) @(posedge clk);
        if (m_out.size() < 2) fail("fill_tags_timeout");
        #1 en0 = 0; en1 = 0; rdy_pct = 0;
        for (int i = 0; i < 30 && !cmd_valid_o; i++) @(posedge clk);
        ctl_keep = 1;
        stale = ctl_words;
        pulse_reset("midop");
        ctl_keep = 0;
        rv_pct = 100;
        for (int i = 0; i < 200 && ctl_words > 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #3 if (stale > 0) chk("err_stale_data", err_o, 1);
        rdy_pct = 100;
        drain();
        #2 if (stale > 0) chk("err_sticky", err_o, 1);
        pulse_reset("err_clear");

        // stray read data with nothing outstanding
        @(posedge clk); #1 stray = 1;
        @(posedge clk); #1 stray = 0;
        repeat (3) @(posedge clk);
        #3 chk("err_stray", err_o, 1);
        chk("stray_no_rvalid", {p1_rvalid_o, p0_rvalid_o}, 0);
        repeat (10) @(posedge clk);
        #3 chk("err_stray_sticky", err_o, 1);
        pulse_reset("stray_clear");

        // final random mix
        en0 = 1; en1 = 1; req0_pct = 50; req1_pct = 50; we_pct = 50; rdy_pct = 70; rv_pct = 60;
        repeat (600) @(posedge clk);
        drain();

        chk("left_cmd", exp_cmd.size(), 0);
        chk("left_rd", exp_rd.size(), 0);
        chk("left_ack", exp_ack.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter g_addr_width, default 24, word address width.
REQ-002 SHALL have parameter g_data_width, default 32, data word width.
REQ-003 SHALL have parameter g_len_width, default 6, burst length field width.
REQ-004 SHALL have parameter g_starve_limit, default 4, max consecutive video grants while CPU waits.
REQ-005 SHALL have parameter g_tag_depth, default 4, outstanding read bursts tracked (power of 2).
REQ-006 SHALL have ports, clock and reset first: clk_sys_i in 1, system clock; rst_i in 1, reset (one clock; reset is synchronous and active-high).
REQ-007 SHALL have video port: p0_req_i in 1; p0_addr_i in g_addr_width; p0_len_i in g_len_width, words; p0_ack_o out 1; p0_rdata_o out g_data_width; p0_rvalid_o out 1.
REQ-008 SHALL have CPU port: p1_req_i in 1; p1_we_i in 1; p1_addr_i in g_addr_width; p1_wdata_i in g_data_width; p1_wmask_i in g_data_width/8; p1_ack_o out 1; p1_rdata_o out g_data_width; p1_rvalid_o out 1.
REQ-009 SHALL have controller side: cmd_valid_o out 1; cmd_ready_i in 1; cmd_we_o out 1; cmd_addr_o out g_addr_width; cmd_len_o out g_len_width; cmd_wdata_o out g_data_width; cmd_wmask_o out g_data_width/8; rdata_i in g_data_width; rvalid_i in 1.
REQ-010 SHALL have err_o out 1, sticky flag for read data with no outstanding tag.

Function
REQ-011 SHALL implement FSM IDLE, ISSUE; IDLE evaluates requests each cycle, ISSUE holds one command until accepted.
REQ-012 SHALL in IDLE grant video when p0_req_i=1 unless p1_req_i=1 and starve counter equals g_starve_limit; else grant CPU if p1_req_i=1.
REQ-013 SHALL increment starve counter on each video grant while p1_req_i=1, clear it on any CPU grant, saturate at g_starve_limit.
REQ-014 SHALL register granted command into cmd_* and assert cmd_valid_o the cycle after the IDLE decision (latency 1), entering ISSUE.
REQ-015 SHALL hold cmd_* and cmd_valid_o stable in ISSUE until cmd_ready_i=1; on that cycle pulse owning pN_ack_o for exactly one cycle and return to IDLE.
REQ-016 SHALL drive video commands with cmd_we_o=0, cmd_len_o=p0_len_i, p0_len_i=0 treated as 1.
REQ-017 SHALL drive CPU commands with cmd_len_o=1, cmd_we_o=p1_we_i, cmd_wdata_o/cmd_wmask_o from port; wdata/wmask SHALL be 0 for reads.
REQ-018 SHALL push {port, len} into tag FIFO on acceptance of every read command; writes SHALL NOT push.
REQ-019 SHALL not grant any read while tag FIFO full; CPU write SHALL still be grantable; ineligible requester SHALL not advance starve counter.
REQ-020 SHALL route each rvalid_i word to head-tag port, registered: pN_rdata_o/pN_rvalid_o one cycle after rvalid_i; other port rvalid 0.
REQ-021 SHALL count words against head length; pop tag on final word; push and pop same cycle SHALL leave occupancy unchanged.
REQ-022 SHALL drop rvalid_i when FIFO empty and set err_o=1 until reset.
REQ-023 Requesters SHALL hold req/addr/len/data stable until ack; arbiter samples port fields at the grant cycle only.

Reset
REQ-024 SHALL on rst_i=1 at a clock edge: FSM=IDLE, cmd_valid_o=0, cmd_we_o=0, cmd_addr_o=0, cmd_len_o=0, cmd_wdata_o=0, cmd_wmask_o=0, p0/p1 ack and rvalid=0, rdata outputs=0, err_o=0, starve counter=0, tag FIFO empty, word counter=0.
REQ-025 SHALL abort in-flight command and discard outstanding tags on reset mid-operation; no ack issued for aborted command.

Verification
REQ-026 Video only, len=8, cmd_ready_i=1, 8 rvalid_i words -> one command len 8, p0_ack_o one pulse, 8 p0_rvalid_o pulses each 1 cycle after rvalid_i, p1_rvalid_o=0.
REQ-027 Both ports requesting continuously, g_starve_limit=4 -> grant sequence V,V,V,V,C repeating.
REQ-028 cmd_ready_i=0 for 10 cycles during ISSUE -> cmd_* stable all 10 cycles, ack only on cycle cmd_ready_i=1.
REQ-029 Four reads outstanding (FIFO full), CPU read and CPU write pending -> write issued, read held until first burst's last word returns.
REQ-030 rvalid_i=1 with empty FIFO -> no port rvalid, err_o=1 held until rst_i.
REQ-031 rst_i asserted in ISSUE with 2 tags outstanding -> all outputs at reset values next cycle, later rvalid_i sets err_o.
